// File: rtl/flow_gen_pkg.sv
// Shared definitions for the flow_gen test-pattern transmitter:
// register map, control fields, pattern modes, FSM states and the throttle LFSR step.
package flow_gen_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_HEIGHT = 2'd2;
  localparam logic [1:0] ADDR_TIMING = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_SINGLE_BIT = 1;
  localparam int CTRL_MODE_LSB   = 2;
  localparam int TIMING_RAND_BIT = 16;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_X     = 2'd1;
  localparam logic [1:0] MODE_Y     = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SOF    = 3'd1;
  localparam state_t ST_ACTIVE = 3'd2;
  localparam state_t ST_EOF    = 3'd3;
  localparam state_t ST_VBLANK = 3'd4;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [1:0]  mode;
    logic [15:0] vgap;
    logic        rand_en;
  } cfg_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0 (bit 0 is the throttle output).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/flow_gen_slave.sv
// Register file for flow_gen: CTRL/WIDTH/HEIGHT/TIMING, registered read mux,
// and the single-shot enable clear requested by the frame FSM.
module flow_gen_slave
  import flow_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr_rel_i,
  input  logic        wr_i,
  input  logic [31:0] datawr_i,
  input  logic        rd_i,
  output logic [31:0] datard_o,
  input  logic [15:0] frame_cnt_i,
  input  logic        busy_i,
  input  logic        en_clr_i,
  output logic        enable_o,
  output logic        single_o,
  output cfg_t        cfg_o
);

  logic        enable_q, enable_d;
  logic        single_q, single_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [15:0] vgap_q, vgap_d;
  logic        rand_en_q, rand_en_d;
  logic [31:0] datard_q, datard_d;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^datawr_i[31:17];

  always_comb begin
    rd_mux = 32'd0;
    case (addr_rel_i)
      ADDR_CTRL:   rd_mux = {frame_cnt_i, busy_i, 11'd0, mode_q, single_q, enable_q};
      ADDR_WIDTH:  rd_mux = {16'd0, width_q};
      ADDR_HEIGHT: rd_mux = {16'd0, height_q};
      ADDR_TIMING: rd_mux = {15'd0, rand_en_q, vgap_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    enable_d  = enable_q;
    single_d  = single_q;
    mode_d    = mode_q;
    width_d   = width_q;
    height_d  = height_q;
    vgap_d    = vgap_q;
    rand_en_d = rand_en_q;
    datard_d  = datard_q;
    if (en_clr_i) enable_d = 1'b0;
    // A CTRL write on the same edge as the single-shot clear takes priority.
    if (wr_i) begin
      case (addr_rel_i)
        ADDR_CTRL: begin
          enable_d = datawr_i[CTRL_EN_BIT];
          single_d = datawr_i[CTRL_SINGLE_BIT];
          mode_d   = datawr_i[CTRL_MODE_LSB +: 2];
        end
        ADDR_WIDTH:  width_d  = datawr_i[15:0];
        ADDR_HEIGHT: height_d = datawr_i[15:0];
        ADDR_TIMING: begin
          vgap_d    = datawr_i[15:0];
          rand_en_d = datawr_i[TIMING_RAND_BIT];
        end
        default: ;
      endcase
    end
    if (rd_i) datard_d = rd_mux;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q  <= 1'b0;
      single_q  <= 1'b0;
      mode_q    <= 2'd0;
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      vgap_q    <= 16'd0;
      rand_en_q <= 1'b0;
      datard_q  <= 32'd0;
    end else begin
      enable_q  <= enable_d;
      single_q  <= single_d;
      mode_q    <= mode_d;
      width_q   <= width_d;
      height_q  <= height_d;
      vgap_q    <= vgap_d;
      rand_en_q <= rand_en_d;
      datard_q  <= datard_d;
    end
  end

  assign datard_o = datard_q;
  assign enable_o = enable_q;
  assign single_o = single_q;
  assign cfg_o    = '{width: width_q, height: height_q, mode: mode_q,
                      vgap: vgap_q, rand_en: rand_en_q};

endmodule

// File: rtl/flow_gen.sv
// Register-configured fv/dv/data frame generator: frame FSM, pixel counters,
// throttle LFSR and pattern selection; registers live in flow_gen_slave.
module flow_gen
  import flow_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  out_fv,
  output logic                  out_dv,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [1:0]            addr_rel_i,
  input  logic                  wr_i,
  input  logic [31:0]           datawr_i,
  input  logic                  rd_i,
  output logic [31:0]           datard_o
);

  state_t                state_q, state_d;
  cfg_t                  live_cfg;
  cfg_t                  sh_q, sh_d;
  logic                  enable, single;
  logic                  en_clr;
  logic                  start_ok;
  logic [15:0]           x_q, x_d;
  logic [15:0]           y_q, y_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [15:0]           vcnt_q, vcnt_d;
  logic [15:0]           vgap_lim;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  fv_q, fv_d;
  logic                  dv_q, dv_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] x_ext, y_ext, pix;
  logic                  allow;

  flow_gen_slave u_slave (
    .clk         (clk),
    .reset_n     (reset_n),
    .addr_rel_i  (addr_rel_i),
    .wr_i        (wr_i),
    .datawr_i    (datawr_i),
    .rd_i        (rd_i),
    .datard_o    (datard_o),
    .frame_cnt_i (frame_cnt_q),
    .busy_i      (state_q != ST_IDLE),
    .en_clr_i    (en_clr),
    .enable_o    (enable),
    .single_o    (single),
    .cfg_o       (live_cfg)
  );

  generate
    if (DATA_WIDTH > 16) begin : g_ext_wide
      assign x_ext = {{(DATA_WIDTH-16){1'b0}}, x_q};
      assign y_ext = {{(DATA_WIDTH-16){1'b0}}, y_q};
    end else if (DATA_WIDTH == 16) begin : g_ext_same
      assign x_ext = x_q;
      assign y_ext = y_q;
    end else begin : g_ext_narrow
      assign x_ext = x_q[DATA_WIDTH-1:0];
      assign y_ext = y_q[DATA_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    case (sh_q.mode)
      MODE_RAMP: pix = idx_q;
      MODE_X:    pix = x_ext;
      MODE_Y:    pix = y_ext;
      default:   pix = x_ext ^ y_ext;
    endcase
  end

  assign start_ok = enable && (live_cfg.width != 16'd0) && (live_cfg.height != 16'd0);
  assign allow    = !sh_q.rand_en || lfsr_q[0];
  assign vgap_lim = (sh_q.vgap == 16'd0) ? 16'd1 : sh_q.vgap;

  // Outputs are computed from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    fv_d        = 1'b0;
    dv_d        = 1'b0;
    data_d      = data_q;
    en_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_SOF;
          sh_d    = live_cfg;
          en_clr  = single;
        end
      end
      ST_SOF: begin
        fv_d    = 1'b1;
        lfsr_d  = LFSR_SEED;
        x_d     = 16'd0;
        y_d     = 16'd0;
        idx_d   = '0;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        fv_d   = 1'b1;
        lfsr_d = lfsr_step(lfsr_q);
        if (allow) begin
          dv_d   = 1'b1;
          data_d = pix;
          idx_d  = idx_q + DATA_WIDTH'(1);
          if (x_q == sh_q.width - 16'd1) begin
            x_d = 16'd0;
            if (y_q == sh_q.height - 16'd1) state_d = ST_EOF;
            else y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      ST_EOF: begin
        fv_d        = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        vcnt_d      = 16'd0;
        state_d     = ST_VBLANK;
      end
      ST_VBLANK: begin
        vcnt_d = vcnt_q + 16'd1;
        if (vcnt_q == vgap_lim - 16'd1) begin
          if (start_ok) begin
            state_d = ST_SOF;
            sh_d    = live_cfg;
            en_clr  = single;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      vcnt_q      <= 16'd0;
      frame_cnt_q <= 16'd0;
      fv_q        <= 1'b0;
      dv_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      fv_q        <= fv_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
    end
  end

  assign out_fv   = fv_q;
  assign out_dv   = dv_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_flow_gen.sv
// Self-checking bench for flow_gen: register vector table, then directed frame sequences.
module tb_flow_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        out_fv, out_dv;
  logic [15:0] out_data;
  logic [1:0]  addr_rel_i = 2'd0;
  logic        wr_i = 1'b0;
  logic [31:0] datawr_i = 32'd0;
  logic        rd_i = 1'b0;
  logic [31:0] datard_o;

  int total = 0;
  int bad   = 0;

  flow_gen #(.DATA_WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .out_fv     (out_fv),
    .out_dv     (out_dv),
    .out_data   (out_data),
    .addr_rel_i (addr_rel_i),
    .wr_i       (wr_i),
    .datawr_i   (datawr_i),
    .rd_i       (rd_i),
    .datard_o   (datard_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  // capture buffers and per-frame analysis results
  logic        fv_log[400];
  logic        dv_log[400];
  logic [15:0] data_log[400];
  int          n_cap;
  int          dv_data[512];
  int          ndv, dv_out, fv_cycles, nfr;
  int          fr_len[16], fr_dv[16], fr_gap[16], fr_first[16], fr_tail[16];
  logic [255:0] fr_pat[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
    @(negedge clk);
    wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_rel_i = a; rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
    d = datard_o;
  endtask

  task automatic capture(input int n);
    n_cap = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fv_log[i] = out_fv;
      dv_log[i] = out_dv;
      data_log[i] = out_data;
    end
  endtask

  task automatic analyze();
    int  start, last_fall, last_dv;
    bit  in_fr;
    ndv = 0; dv_out = 0; fv_cycles = 0; nfr = 0;
    in_fr = 0; last_fall = -1; start = 0; last_dv = -1;
    for (int k = 0; k < 16; k++) begin
      fr_len[k] = -1; fr_dv[k] = 0; fr_gap[k] = -1; fr_first[k] = -1; fr_tail[k] = -1; fr_pat[k] = '0;
    end
    for (int i = 0; i < n_cap; i++) begin
      if (fv_log[i]) fv_cycles++;
      if (dv_log[i]) begin
        if (ndv < 512) dv_data[ndv] = int'(data_log[i]);
        ndv++;
        if (!fv_log[i]) dv_out++;
      end
      if (fv_log[i] && (i == 0 || !fv_log[i-1]) && nfr < 16) begin
        in_fr = 1; start = i; last_dv = -1;
        fr_gap[nfr] = (last_fall >= 0) ? i - last_fall : -1;
      end
      if (in_fr && fv_log[i] && dv_log[i]) begin
        fr_dv[nfr]++;
        if (i - start < 256) fr_pat[nfr][i - start] = 1'b1;
        if (fr_first[nfr] < 0) fr_first[nfr] = i - start;
        last_dv = i - start;
      end
      if (in_fr && !fv_log[i]) begin
        fr_len[nfr] = i - start;
        fr_tail[nfr] = (i - start) - last_dv;
        nfr++; in_fr = 0; last_fall = i;
      end
    end
  endtask

  logic [31:0] rv, rv2;
  int exp4[14] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 0, 1};
  int exp2[6]  = '{0, 1, 2, 1, 0, 3};

  initial begin
    vecs[0]  = '{"rst_ctrl",    2'd0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[1]  = '{"rst_timing",  2'd3, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[2]  = '{"hold_wwidth", 2'd1, 1'b1, 32'h12345678, 1'b0, 32'h0};
    vecs[3]  = '{"rd_width",    2'd1, 1'b0, 32'h0,        1'b1, 32'h00005678};
    vecs[4]  = '{"coll_height", 2'd2, 1'b1, 32'hFFFF0003, 1'b1, 32'h0};
    vecs[5]  = '{"rd_height",   2'd2, 1'b0, 32'h0,        1'b1, 32'h00000003};
    vecs[6]  = '{"hold_wtim",   2'd3, 1'b1, 32'hFFFF1234, 1'b0, 32'h00000003};
    vecs[7]  = '{"rd_timing",   2'd3, 1'b0, 32'h0,        1'b1, 32'h00011234};
    vecs[8]  = '{"coll_ctrl",   2'd0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h0};
    vecs[9]  = '{"rd_ctrl",     2'd0, 1'b0, 32'h0,        1'b1, 32'h0000000E};
    vecs[10] = '{"hold_wctrl",  2'd0, 1'b1, 32'h0,        1'b0, 32'h0000000E};
    vecs[11] = '{"rd_ctrl0",    2'd0, 1'b0, 32'h0,        1'b1, 32'h0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_fv", {31'd0, out_fv}, 32'd0);
    chk("rst_dv", {31'd0, out_dv}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_datard", datard_o, 32'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      addr_rel_i = vecs[i].addr; wr_i = vecs[i].wr; datawr_i = vecs[i].wdata; rd_i = vecs[i].rd;
      @(negedge clk);
      wr_i = 1'b0; rd_i = 1'b0;
      chk(vecs[i].nm, datard_o, vecs[i].exp);
    end

    // single frame, ramp 4x2
    do_reset();
    reg_write(2'd1, 32'd4);
    reg_write(2'd2, 32'd2);
    reg_write(2'd3, 32'd0);
    fork
      capture(40);
      reg_write(2'd0, 32'h3);
    join
    analyze();
    chk("t1_frames", nfr, 1);
    chk("t1_fv_cycles", fv_cycles, 10);
    chk("t1_dv_count", ndv, 8);
    chk("t1_dv_outside", dv_out, 0);
    chk("t1_lead", fr_first[0], 1);
    chk("t1_tail", fr_tail[0], 2);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_data%0d", i), dv_data[i], i);
    reg_read(2'd0, rv);
    chk("t1_ctrl", rv, 32'h00010002);

    // continuous checker 3x2, vgap 3
    do_reset();
    reg_write(2'd1, 32'd3);
    reg_write(2'd2, 32'd2);
    reg_write(2'd3, 32'd3);
    fork
      capture(60);
      reg_write(2'd0, 32'hD);
    join
    analyze();
    chk("t2_len0", fr_len[0], 8);
    chk("t2_gap1", fr_gap[1], 3);
    chk("t2_gap2", fr_gap[2], 3);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_data%0d", i), dv_data[i], exp2[i % 6]);
    reg_read(2'd0, rv);
    repeat (9) @(negedge clk);
    reg_read(2'd0, rv2);
    chk("t2_cnt_step", 32'(rv2[31:16] - rv[31:16]), 32'd1);

    // random throttle 8x4
    do_reset();
    reg_write(2'd1, 32'd8);
    reg_write(2'd2, 32'd4);
    reg_write(2'd3, 32'h00010000);
    fork
      capture(400);
      reg_write(2'd0, 32'h1);
    join
    analyze();
    chk("t3_two_frames", 32'(nfr >= 2), 32'd1);
    chk("t3_dv0", fr_dv[0], 32);
    chk("t3_dv1", fr_dv[1], 32);
    chk("t3_dv_outside", dv_out, 0);
    chk("t3_throttled", 32'(fr_len[0] > 34), 32'd1);
    chk("t3_len_same", fr_len[1], fr_len[0]);
    chk("t3_pat_same", 32'(fr_pat[0] == fr_pat[1]), 32'd1);
    chk("t3_lead", fr_first[0], 1);
    chk("t3_tail", fr_tail[0], 2);

    // width change mid-frame, mode X
    do_reset();
    reg_write(2'd1, 32'd5);
    reg_write(2'd2, 32'd2);
    reg_write(2'd3, 32'd0);
    fork
      capture(40);
      begin
        reg_write(2'd0, 32'h5);
        repeat (5) @(negedge clk);
        reg_write(2'd1, 32'd2);
      end
    join
    analyze();
    chk("t4_dv0", fr_dv[0], 10);
    chk("t4_dv1", fr_dv[1], 4);
    for (int i = 0; i < 14; i++) chk($sformatf("t4_data%0d", i), dv_data[i], exp4[i]);

    // reset mid-ACTIVE
    do_reset();
    reg_write(2'd1, 32'd8);
    reg_write(2'd2, 32'd8);
    reg_write(2'd0, 32'h1);
    repeat (8) @(negedge clk);
    chk("t5_pre_fv", {31'd0, out_fv}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t5_fv", {31'd0, out_fv}, 32'd0);
    chk("t5_dv", {31'd0, out_dv}, 32'd0);
    chk("t5_data", {16'd0, out_data}, 32'd0);
    capture(50);
    analyze();
    chk("t5_no_fv", fv_cycles, 0);
    reg_read(2'd0, rv);
    chk("t5_ctrl", rv, 32'd0);
    reg_read(2'd1, rv);
    chk("t5_width", rv, 32'd0);

    // zero height holds IDLE, then minimal 1x1 frame
    do_reset();
    reg_write(2'd1, 32'd4);
    reg_write(2'd2, 32'd0);
    fork
      capture(100);
      reg_write(2'd0, 32'h1);
    join
    analyze();
    chk("t6_no_fv", fv_cycles, 0);
    reg_read(2'd0, rv);
    chk("t6_ctrl_idle", rv, 32'h00000001);
    fork
      capture(30);
      begin
        reg_write(2'd1, 32'd1);
        reg_write(2'd2, 32'd1);
      end
    join
    analyze();
    chk("t6_len", fr_len[0], 3);
    chk("t6_dv", fr_dv[0], 1);
    chk("t6_lead", fr_first[0], 1);
    chk("t6_data", dv_data[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
